// File: rtl/cla_pkg.sv
// Shared defaults and per-stage control record for the pipelined CLA adder/subtractor.
// Data fields of a stage record (sum chunks, pending a/b) are WIDTH-dependent and live in the top.
package cla_pkg;

   localparam int CLA_WIDTH = 16;
   localparam int CLA_BLOCK = 4;

   typedef struct packed {
      logic valid;
      logic carry;
   } cla_ctrl_t;

   function automatic int cla_nstg(input int width, input int block);
      return width / block;
   endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice: every carry is a flat sum of
// generate terms gated by propagate runs, so no carry depends on another carry.
module cla_block
   import cla_pkg::*;
#(
   parameter int BLOCK = CLA_BLOCK
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             ci,
   output logic [BLOCK-1:0] s,
   output logic             co
);

   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] p;
   logic [BLOCK:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      logic term;
      logic carry;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < BLOCK; i++) begin
         term = ci;
         for (int j = 0; j <= i; j++) begin
            term = term & p[j];
         end
         carry = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) begin
               term = term & p[k];
            end
            carry = carry | term;
         end
         c[i+1] = carry;
      end
   end

   assign s  = p ^ c[BLOCK-1:0];
   assign co = c[BLOCK];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor, one BLOCK-bit chunk resolved per stage, valid/ready on both sides.
// Optional signed-overflow and zero flags are built when CLA_FLAGS_EN is defined.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int BLOCK = CLA_BLOCK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSTG  = cla_nstg(WIDTH, BLOCK);
   localparam int NPEND = (NSTG > 1) ? NSTG - 1 : 1;

   if ((WIDTH % BLOCK) != 0 || NSTG < 1) begin : g_bad_cfg
      $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
   end

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   cla_ctrl_t        ctrl_q [NSTG];
   logic [WIDTH-1:0] sum_q  [NSTG];
   logic [WIDTH-1:0] pa_q   [NPEND];
   logic [WIDTH-1:0] pb_q   [NPEND];

   assign b_eff = sub ? ~b : b;
   assign c0    = cin ^ sub;

   // One shared enable: the whole pipe freezes, bubbles included, while the output is blocked.
   assign out_valid = ctrl_q[NSTG-1].valid;
   assign sum       = sum_q[NSTG-1];
   assign cout      = ctrl_q[NSTG-1].carry;
   assign en        = !out_valid || out_ready;
   assign in_ready  = en;

   for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic [WIDTH-1:0] src_sum;
      logic [WIDTH-1:0] sum_d;
      logic             src_v;
      logic             src_c;
      logic [BLOCK-1:0] s_chunk;
      logic             co_chunk;

      if (gi == 0) begin : g_head
         assign src_a   = a;
         assign src_b   = b_eff;
         assign src_sum = '0;
         assign src_v   = in_valid;
         assign src_c   = c0;
      end else begin : g_tail
         assign src_a   = pa_q[gi-1];
         assign src_b   = pb_q[gi-1];
         assign src_sum = sum_q[gi-1];
         assign src_v   = ctrl_q[gi-1].valid;
         assign src_c   = ctrl_q[gi-1].carry;
      end

      cla_block #(.BLOCK(BLOCK)) u_cla (
         .a  (src_a[gi*BLOCK +: BLOCK]),
         .b  (src_b[gi*BLOCK +: BLOCK]),
         .ci (src_c),
         .s  (s_chunk),
         .co (co_chunk)
      );

      always_comb begin
         sum_d                     = src_sum;
         sum_d[gi*BLOCK +: BLOCK]  = s_chunk;
      end

      // Data only loads with a real op, so bubbles never disturb the visible result.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ctrl_q[gi] <= '0;
            sum_q[gi]  <= '0;
         end else if (en) begin
            ctrl_q[gi].valid <= src_v;
            if (src_v) begin
               ctrl_q[gi].carry <= co_chunk;
               sum_q[gi]        <= sum_d;
            end
         end
      end

      if (gi < NSTG - 1) begin : g_pend
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pa_q[gi] <= '0;
               pb_q[gi] <= '0;
            end else if (en && src_v) begin
               pa_q[gi] <= src_a;
               pb_q[gi] <= src_b;
            end
         end
      end

      if (gi == NSTG - 1) begin : g_out
`ifdef CLA_FLAGS_EN
         logic ovf_q;
         logic zero_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (en && src_v) begin
               ovf_q  <= (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum_d[WIDTH-1] != src_a[WIDTH-1]);
               zero_q <= (sum_d == '0);
            end
         end

         assign ovf  = ovf_q;
         assign zero = zero_q;
`else
         assign ovf  = 1'b0;
         assign zero = 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and scoreboarded random checks for pipelined_cla_adder at WIDTH=16, BLOCK=4.
// Flag expectations follow CLA_FLAGS_EN the same way the design does.
module tb_pipelined_cla_adder;

   typedef struct packed {
      logic        sub;
      logic        cin;
      logic [15:0] a;
      logic [15:0] b;
   } op_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        zero;

   int tests;
   int fails;
   int cyc;
   int nsent;
   int nrecv;
   logic [18:0] sb [$];
   op_t t5_vec [8];

   pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns {zero, ovf, cout, sum}.
   function automatic logic [18:0] model(input logic [15:0] xa, input logic [15:0] xb,
                                         input logic xcin, input logic xsub);
      logic [15:0] be;
      logic [16:0] full;
      logic        o;
      logic        z;
      be   = xsub ? ~xb : xb;
      full = {1'b0, xa} + {1'b0, be} + {16'd0, xcin ^ xsub};
`ifdef CLA_FLAGS_EN
      o = (xa[15] == be[15]) && (full[15] != xa[15]);
      z = (full[15:0] == 16'h0000);
`else
      o = 1'b0;
      z = 1'b0;
`endif
      return {z, o, full[16], full[15:0]};
   endfunction

   // One clock with scoreboard bookkeeping; inputs must already be set.
   task automatic step();
      logic        acc_in;
      logic        acc_out;
      logic        held;
      logic [15:0] hsum;
      logic        hcout;
      logic [18:0] e;
      #1;
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
         if (sb.size() == 0) begin
            chk("spurious_result", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("stream_sum", {16'd0, sum}, {16'd0, e[15:0]});
            chk("stream_cout", {31'd0, cout}, {31'd0, e[16]});
            chk("stream_ovf", {31'd0, ovf}, {31'd0, e[17]});
            chk("stream_zero", {31'd0, zero}, {31'd0, e[18]});
            nrecv++;
         end
      end
      if (acc_in) begin
         sb.push_back(model(a, b, cin, sub));
         nsent++;
      end
      held  = out_valid && !out_ready;
      hsum  = sum;
      hcout = cout;
      tick();
      if (held) begin
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_sum", {16'd0, sum}, {16'd0, hsum});
         chk("hold_cout", {31'd0, cout}, {31'd0, hcout});
      end
      cyc++;
   endtask

   task automatic run_op(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                         input logic xcin, input logic xsub, input logic [15:0] esum,
                         input logic ecout, input logic eovf, input logic ezero);
      int n;
      logic eo;
      logic ez;
`ifdef CLA_FLAGS_EN
      eo = eovf;
      ez = ezero;
`else
      eo = 1'b0;
      ez = 1'b0;
`endif
      a = xa; b = xb; cin = xcin; sub = xsub;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, 32'd4);
      chk({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
      chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
      chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
      chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
      tick();
      chk({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      tests = 0; fails = 0; cyc = 0; nsent = 0; nrecv = 0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_sum", {16'd0, sum}, 32'd0);
      chk("reset_cout", {31'd0, cout}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

      run_op("t1_carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
      run_op("t2_wrap_zero",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      run_op("t3_sub_borrow",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      run_op("t3_sub_noborrow",16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
      run_op("t4_add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      run_op("t4_sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      run_op("add_cin",        16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
      run_op("sub_bin",        16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0);

      // Eight back-to-back ops with the output blocked in cycles 6..8.
      t5_vec[0] = {1'b0, 1'b0, 16'h0001, 16'h0002};
      t5_vec[1] = {1'b0, 1'b1, 16'h0F0F, 16'h00F1};
      t5_vec[2] = {1'b1, 1'b0, 16'h1000, 16'h0001};
      t5_vec[3] = {1'b0, 1'b0, 16'hFFFF, 16'hFFFF};
      t5_vec[4] = {1'b1, 1'b1, 16'h0000, 16'h0000};
      t5_vec[5] = {1'b0, 1'b0, 16'hABCD, 16'h1234};
      t5_vec[6] = {1'b1, 1'b0, 16'h8000, 16'h8000};
      t5_vec[7] = {1'b0, 1'b1, 16'h7FFE, 16'h0000};
      sb.delete();
      cyc = 0; nsent = 0; nrecv = 0;
      while (nrecv < 8 && cyc < 60) begin
         in_valid = (nsent < 8);
         if (nsent < 8) begin
            {sub, cin, a, b} = t5_vec[nsent];
         end
         out_ready = !(cyc >= 6 && cyc <= 8);
         #1;
         if (cyc < 12) begin
            chk("t5_in_ready", {31'd0, in_ready}, (cyc >= 6 && cyc <= 8) ? 32'd0 : 32'd1);
         end
         step();
      end
      chk("t5_received", nrecv, 32'd8);
      chk("t5_sb_empty", sb.size(), 32'd0);

      // Random traffic with random bubbles and stalls.
      cyc = 0; nsent = 0; nrecv = 0;
      while (nrecv < 1000 && cyc < 20000) begin
         in_valid  = (nsent < 1000) && ($urandom_range(0, 4) != 0);
         a         = 16'($urandom);
         b         = 16'($urandom);
         cin       = 1'($urandom_range(0, 1));
         sub       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      chk("rand_received", nrecv, 32'd1000);
      chk("rand_sb_empty", sb.size(), 32'd0);

      // Reset with three ops in flight and the first one sitting at the output.
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      sb.delete();
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
      step();
      a = 16'h3333; b = 16'h0001; step();
      a = 16'hF000; b = 16'h0F00; step();
      in_valid = 1'b0;
      for (int n = 0; n < 10 && !out_valid; n++) begin
         step();
      end
      chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_async_sum", {16'd0, sum}, 32'd0);
      chk("t6_async_cout", {31'd0, cout}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      sb.delete();
      run_op("t6_after_reset", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
      begin
         int stale;
         stale = 0;
         for (int n = 0; n < 8; n++) begin
            tick();
            if (out_valid) stale++;
         end
         chk("t6_no_stale", stale, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
